// File: rtl/histogram_readout_pkg.sv
// Shared constants and FSM encoding for the histogram readout sweep.
package histogram_readout_pkg;

    localparam int READ_LATENCY = 2;
    localparam int WAIT_STATES  = READ_LATENCY;
    localparam int FIFO_DEPTH   = 2;
    localparam int STATE_BITS   = 4 + WAIT_STATES;

    typedef enum logic [STATE_BITS-1:0] {
        IDLE  = STATE_BITS'(1 << 0),
        RD    = STATE_BITS'(1 << 1),
        W1    = STATE_BITS'(1 << 2),
        W2    = STATE_BITS'(1 << 3),
        WR    = STATE_BITS'(1 << 4),
        FLUSH = STATE_BITS'(1 << 5)
    } state_t;

endpackage

// File: rtl/histogram_readout_if.sv
// Port-B memory bus and output stream bundles for the readout sweep.
interface hist_mem_if #(
    parameter int AW = 10,
    parameter int DW = 16
);
    logic [AW-1:0] mem_address;
    logic          mem_wren;
    logic [DW-1:0] mem_data;
    logic          mem_clken;
    logic [DW-1:0] mem_q;

    modport master (
        output mem_address, mem_wren, mem_data, mem_clken,
        input  mem_q
    );
    modport slave (
        input  mem_address, mem_wren, mem_data, mem_clken,
        output mem_q
    );
endinterface

interface hist_stream_if #(
    parameter int DW = 16
);
    logic [DW-1:0] out_data;
    logic          out_dv;
    logic          out_last;
    logic          out_fv;
    logic          out_ready;

    modport master (
        output out_data, out_dv, out_last, out_fv,
        input  out_ready
    );
    modport slave (
        input  out_data, out_dv, out_last, out_fv,
        output out_ready
    );
endinterface

// File: rtl/histogram_readout_fifo.sv
// Two-entry output FIFO; entry 0 is the registered stream head.
module hist_out_fifo
    import histogram_readout_pkg::*;
#(
    parameter int WIDTH = 17,
    localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             head_valid,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] d0, d1, d0_n, d1_n;
    logic             v0, v1, v0_n, v1_n;

    always_comb begin
        d0_n = d0;
        d1_n = d1;
        v0_n = v0;
        v1_n = v1;
        if (pop && v0) begin
            d0_n = d1;
            v0_n = v1;
            v1_n = 1'b0;
        end
        if (push) begin
            if (!v0_n) begin
                d0_n = push_data;
                v0_n = 1'b1;
            end else begin
                d1_n = push_data;
                v1_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d0 <= '0;
            d1 <= '0;
            v0 <= 1'b0;
            v1 <= 1'b0;
        end else begin
            d0 <= d0_n;
            d1 <= d1_n;
            v0 <= v0_n;
            v1 <= v1_n;
        end
    end

    assign head       = d0;
    assign head_valid = v0;
    assign count      = CW'(v0) + CW'(v1);
    assign full       = (count == CW'(FIFO_DEPTH));
    assign empty      = (count == '0);

endmodule

// File: rtl/histogram_readout.sv
// Post-frame histogram sweep: read each bin, stream it out, write zero back.
module histogram_readout
    import histogram_readout_pkg::*;
#(
    parameter int HISTOGRAM_WIDTH = 16,
    parameter int HISTMEM_WORD = 1024,
    localparam int HISTMEM_ADDR_WIDTH = $clog2(HISTMEM_WORD)
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      start,
    input  logic      clear_only,
    output logic      busy,
    output logic      done,
    hist_mem_if.master    mem,
    hist_stream_if.master out
);

    localparam int AW = HISTMEM_ADDR_WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW-1:0] LAST = AW'(HISTMEM_WORD - 1);

    state_t                   state;
    logic [AW-1:0]            addr;
    logic                     wren;
    logic                     clr;
    logic                     fv;
    logic                     push;
    logic                     pop;
    logic                     drained;
    logic [HISTOGRAM_WIDTH:0] head;
    logic                     head_valid;
    logic [CW-1:0]            fifo_count;
    logic                     fifo_full;
    logic                     fifo_empty;

    assign push = (state == WR) && !clr;
    assign pop  = head_valid && out.out_ready;
    assign drained = fifo_empty || (fifo_count == CW'(1) && pop);

    hist_out_fifo #(
        .WIDTH(HISTOGRAM_WIDTH + 1)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_data  ({addr == LAST, mem.mem_q}),
        .pop        (pop),
        .head       (head),
        .head_valid (head_valid),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // One read in flight: a bin is zeroed in WR only after its value is captured.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            addr  <= '0;
            wren  <= 1'b0;
            clr   <= 1'b0;
        end else begin
            done <= 1'b0;
            wren <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= RD;
                        busy  <= 1'b1;
                        addr  <= '0;
                        clr   <= clear_only;
                    end
                end
                RD: begin
                    if (clr || !fifo_full) state <= W1;
                end
                W1: state <= W2;
                W2: begin
                    state <= WR;
                    wren  <= 1'b1;
                end
                WR: begin
                    if (addr != LAST) begin
                        addr  <= addr + 1'b1;
                        state <= RD;
                    end else if (clr) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (drained) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) fv <= 1'b0;
        else if (push) fv <= 1'b1;
        else if (pop && head[HISTOGRAM_WIDTH]) fv <= 1'b0;
    end

    assign mem.mem_address = addr;
    assign mem.mem_wren    = wren;
    assign mem.mem_data    = '0;
    assign mem.mem_clken   = busy;

    assign out.out_data = head[HISTOGRAM_WIDTH-1:0];
    assign out.out_last = head[HISTOGRAM_WIDTH];
    assign out.out_dv   = head_valid;
    assign out.out_fv   = fv;

endmodule

// File: tb/tb_histogram_readout.sv
// Scoreboard bench for histogram_readout at 1024, 8 and 6 bins.
module tb_histogram_readout;

    localparam int DW = 16;
    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst   [NI];
    logic start [NI];
    logic clr   [NI];
    logic rdy   [NI];
    logic busy  [NI];
    logic done  [NI];

    int n_pass = 0;
    int n_tot  = 0;

    task automatic check(input bit ok, input string name,
                         input int act, input int exp);
        n_tot++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_i
        localparam int W  = (g == 0) ? 1024 : ((g == 1) ? 8 : 6);
        localparam int AW = $clog2(W);

        hist_mem_if #(.AW(AW), .DW(DW)) mi ();
        hist_stream_if #(.DW(DW)) so ();

        histogram_readout #(
            .HISTOGRAM_WIDTH(DW),
            .HISTMEM_WORD   (W)
        ) dut (
            .clk       (clk),
            .reset     (rst[g]),
            .start     (start[g]),
            .clear_only(clr[g]),
            .busy      (busy[g]),
            .done      (done[g]),
            .mem       (mi),
            .out       (so)
        );

        assign so.out_ready = rdy[g];

        // Port-B model: registered address, registered output.
        logic [DW-1:0] ram [W];
        logic [AW-1:0] ra;
        logic [DW-1:0] q;
        logic fill = 1'b0;
        logic fill_ones = 1'b0;

        always @(posedge clk) begin
            if (fill) begin
                for (int i = 0; i < W; i++)
                    ram[i] <= fill_ones ? 16'hFFFF : DW'(i + 1);
            end else if (mi.mem_clken) begin
                ra <= mi.mem_address;
                q  <= ram[ra];
                if (mi.mem_wren) ram[mi.mem_address] <= mi.mem_data;
            end
        end
        assign mi.mem_q = q;

        logic [9:0] obs;
        assign obs = {busy[g], done[g], mi.mem_wren, mi.mem_clken,
                      so.out_dv, so.out_last, so.out_fv,
                      |mi.mem_address, |mi.mem_data, |so.out_data};

        logic [DW:0] exp_q [$];
        logic [DW:0] e;
        logic [DW:0] held;
        int words = 0;
        int addr_bad = 0;
        int occ = 0;
        bit stall_prev = 1'b0;

        always @(negedge clk) begin
            if (rst[g]) begin
                occ = 0;
                stall_prev = 1'b0;
            end else begin
                if (int'(mi.mem_address) >= W) addr_bad++;
                if (stall_prev)
                    check(so.out_dv && {so.out_last, so.out_data} == held,
                          "stall hold", int'({so.out_last, so.out_data}),
                          int'(held));
                if (mi.mem_wren && !clr[g]) begin
                    check(occ <= 1, "fifo room at write", occ, 1);
                    occ++;
                end
                if (so.out_dv && rdy[g]) begin
                    occ--;
                    check(exp_q.size() != 0, "unexpected word",
                          int'(so.out_data), 0);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check({so.out_fv, so.out_last, so.out_data} == {1'b1, e},
                              "word", int'({so.out_fv, so.out_last, so.out_data}),
                              int'({1'b1, e}));
                        words++;
                    end
                end
                stall_prev = so.out_dv && !rdy[g];
                held = {so.out_last, so.out_data};
            end
        end
    end

    // mode: 0 ready high, 1 toggle every 3 cycles, 2 long stall
    task automatic run_sweep(input int k, input bit c, input int limit,
                             input int again, input int mode, output int n);
        @(posedge clk);
        #1;
        clr[k]   = c;
        start[k] = 1'b1;
        n = 0;
        while (n < limit) begin
            @(posedge clk);
            n++;
            #1;
            if (n == 1) start[k] = 1'b0;
            if (n == again) start[k] = 1'b1;
            else if (n == again + 1) start[k] = 1'b0;
            if (mode == 1 && n % 3 == 0) rdy[k] = !rdy[k];
            if (mode == 2 && n == 5) rdy[k] = 1'b0;
            if (mode == 2 && n == 30) rdy[k] = 1'b1;
            @(negedge clk);
            if (done[k]) break;
        end
        check(n < limit, "done seen", n, limit);
        rdy[k] = 1'b1;
        clr[k] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int nz;
        for (int k = 0; k < NI; k++) begin
            rst[k]   = 1'b1;
            start[k] = 1'b0;
            clr[k]   = 1'b0;
            rdy[k]   = 1'b1;
        end
        g_i[0].fill = 1'b1;
        g_i[1].fill = 1'b1;
        g_i[2].fill = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        g_i[0].fill = 1'b0;
        g_i[1].fill = 1'b0;
        g_i[2].fill = 1'b0;
        for (int k = 0; k < NI; k++) rst[k] = 1'b0;
        @(negedge clk);
        check(g_i[0].obs == '0, "reset outputs 1024", int'(g_i[0].obs), 0);
        check(g_i[1].obs == '0, "reset outputs 8", int'(g_i[1].obs), 0);
        check(g_i[2].obs == '0, "reset outputs 6", int'(g_i[2].obs), 0);

        // Full 1024-bin sweep, extra start at cycle 100 is ignored.
        for (int i = 0; i < 1024; i++)
            g_i[0].exp_q.push_back({i == 1023, DW'(i + 1)});
        run_sweep(0, 1'b0, 5000, 100, 0, n);
        check(n == 4098, "full sweep done cycle", n, 4098);
        check(!busy[0], "busy falls with done", int'(busy[0]), 0);
        @(negedge clk);
        check(!done[0], "done single pulse", int'(done[0]), 0);
        repeat (5) @(negedge clk);
        check(!busy[0] && !g_i[0].so.out_fv, "idle after sweep",
              int'({busy[0], g_i[0].so.out_fv}), 0);
        check(g_i[0].words == 1024, "full sweep words", g_i[0].words, 1024);
        nz = 0;
        for (int i = 0; i < 1024; i++) if (g_i[0].ram[i] != '0) nz++;
        check(nz == 0, "full sweep bins cleared", nz, 0);

        // Backpressure: ready toggling every 3 cycles, then a long stall.
        for (int m = 1; m <= 2; m++) begin
            @(posedge clk);
            #1 g_i[1].fill = 1'b1;
            @(posedge clk);
            #1 g_i[1].fill = 1'b0;
            g_i[1].words = 0;
            for (int i = 0; i < 8; i++)
                g_i[1].exp_q.push_back({i == 7, DW'(i + 1)});
            run_sweep(1, 1'b0, 500, 0, m, n);
            check(g_i[1].words == 8, "backpressure words", g_i[1].words, 8);
            check(g_i[1].exp_q.size() == 0, "backpressure leftover",
                  g_i[1].exp_q.size(), 0);
        end

        // Clear-only on a saturated memory.
        @(posedge clk);
        #1 g_i[1].fill_ones = 1'b1;
        g_i[1].fill = 1'b1;
        @(posedge clk);
        #1 g_i[1].fill = 1'b0;
        g_i[1].fill_ones = 1'b0;
        g_i[1].words = 0;
        run_sweep(1, 1'b1, 500, 0, 0, n);
        check(n == 33, "clear_only done cycle", n, 33);
        check(g_i[1].words == 0, "clear_only streamed", g_i[1].words, 0);
        nz = 0;
        for (int i = 0; i < 8; i++) if (g_i[1].ram[i] != '0) nz++;
        check(nz == 0, "clear_only bins cleared", nz, 0);

        // Reset while reading bin 5 of 8.
        @(posedge clk);
        #1 g_i[1].fill = 1'b1;
        @(posedge clk);
        #1 g_i[1].fill = 1'b0;
        for (int i = 0; i < 8; i++)
            g_i[1].exp_q.push_back({i == 7, DW'(i + 1)});
        start[1] = 1'b1;
        @(posedge clk);
        #1 start[1] = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst[1] = 1'b1;
        @(negedge clk);
        check(int'(g_i[1].mi.mem_address) == 5, "address at bin 5",
              int'(g_i[1].mi.mem_address), 5);
        @(posedge clk);
        #1 rst[1] = 1'b0;
        @(negedge clk);
        check(g_i[1].obs == '0, "mid-sweep reset outputs",
              int'(g_i[1].obs), 0);
        g_i[1].exp_q.delete();
        g_i[1].words = 0;
        for (int i = 0; i < 8; i++)
            g_i[1].exp_q.push_back({i == 7, (i < 5) ? 16'd0 : DW'(i + 1)});
        run_sweep(1, 1'b0, 500, 0, 0, n);
        check(n == 34, "restart done cycle", n, 34);
        check(g_i[1].words == 8, "restart words", g_i[1].words, 8);

        // Six bins: not a power of two.
        for (int i = 0; i < 6; i++)
            g_i[2].exp_q.push_back({i == 5, DW'(i + 1)});
        run_sweep(2, 1'b0, 500, 0, 0, n);
        check(n == 26, "six-bin done cycle", n, 26);
        check(g_i[2].words == 6, "six-bin words", g_i[2].words, 6);
        check(g_i[2].addr_bad == 0, "six-bin address range",
              g_i[2].addr_bad, 0);
        nz = 0;
        for (int i = 0; i < 6; i++) if (g_i[2].ram[i] != '0) nz++;
        check(nz == 0, "six-bin bins cleared", nz, 0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/histogram_readout.md
# histogram_readout

Sweeps the histogram memory after each frame: reads every bin through the RAM's second port, streams the bin values out with a ready/valid handshake, and writes zero back to each bin. It replaces the bare clear path on that port and asserts `busy` so the accumulate side stops updating bins during the sweep.

## Interface
Parameters:
- `HISTOGRAM_WIDTH`, 16, bin value width.
- `HISTMEM_WORD`, 1024, number of bins. Any value ≥ 2; need not be a power of two.
- `HISTMEM_ADDR_WIDTH`, localparam `$clog2(HISTMEM_WORD)`.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request to begin a sweep.
- `clear_only` in 1: sampled with `start`. When 1, bins are zeroed and no data is streamed.
- `busy` out 1: high from the cycle after an accepted `start` until `done`. The accumulate side must gate its `data_valid_in` with this.
- `done` out 1: one-cycle pulse when the sweep completes.
- `mem_address` out `HISTMEM_ADDR_WIDTH`: port-B address.
- `mem_wren` out 1: port-B write enable.
- `mem_data` out `HISTOGRAM_WIDTH`: port-B write data, constant 0.
- `mem_clken` out 1: RAM clock enable. Equal to `busy`.
- `mem_q` in `HISTOGRAM_WIDTH`: port-B read data. Read latency is 2 cycles (registered address, registered output).
- `out_data` out `HISTOGRAM_WIDTH`: bin value.
- `out_dv` out 1: `out_data` is valid.
- `out_last` out 1: qualifies the word for bin `HISTMEM_WORD-1`.
- `out_fv` out 1: high from the first `out_dv` through the cycle of the last transfer.
- `out_ready` in 1: consumer accepts the word when `out_dv && out_ready`.

## Operation
- States:
  - `IDLE`
  - `RD`: present the address, `mem_wren=0`.
  - `W1`
  - `W2`
  - `WR`: `mem_q` is valid. Present the same address with `mem_wren=1`. Push `mem_q` into the output FIFO unless `clear_only`.
  - `FLUSH`
- Transitions:
  - `IDLE` → `RD` on `start`.
  - `RD` → `W1` only when the FIFO has a free slot, or when `clear_only` is set. Otherwise stay in `RD` with `mem_wren=0`.
  - `W1` → `W2` → `WR`.
  - `WR` → `RD` with the address incremented, unless the address is `HISTMEM_WORD-1`.
  - From the last bin: `WR` → `FLUSH`. `FLUSH` waits until the FIFO is empty, then pulses `done` and returns to `IDLE`.
- Only one read is ever in flight, so the FIFO is 2 entries deep and can never overflow.
- The address counter resets to 0 at every accepted `start`. There is no wrap beyond `HISTMEM_WORD-1`.
- `start` while `busy` is ignored and does not queue.
- `clear_only` is latched at `start`. Changes during the sweep have no effect.
- A bin is cleared only after its value has been captured, so no counts are lost.
- Reset mid-sweep: return to `IDLE` and empty the FIFO. The memory is left partially cleared; the next `start` sweeps from bin 0.
- Reset values: `busy`, `done`, `mem_wren`, `mem_clken`, `out_dv`, `out_last` and `out_fv` are 0; `mem_address`, `mem_data` and `out_data` are 0.

## Timing
- `start` high in cycle 0: `busy=1` and state `RD` in cycle 1.
- First read: `mem_address=0` from cycle 1, `mem_q` is sampled in cycle 4 (`WR`), and `out_dv` can first rise in cycle 5.
- Throughput: 4 cycles per bin when `out_ready` is held high. A full sweep is `4*HISTMEM_WORD` cycles, plus 2 cycles of drain, until `done`.
- `done` rises in the cycle after the last FIFO pop; `busy` falls in that same cycle.
- In `clear_only` mode, `done` comes 1 cycle after the last `WR`.
- `out_dv` and `out_data` remain stable while `out_ready=0`.
- All outputs are registered.

## Structure
- Shared histogram package holds:
  - the state encoding (one-hot, 6 bits);
  - the `READ_LATENCY=2` constant;
  - the FIFO depth constant (2).
- The `WAIT` state count derives from `READ_LATENCY`.
- One sub-module, `hist_out_fifo`: a 2-entry synchronous FIFO providing `count`, `full` and `empty`.

## Test plan
- Full sweep: preload bins with `bin[i]=i+1` and hold `out_ready=1`. Expect 1024 words with values 1..1024, `out_last` on the value 1024, `done` at cycle 4098, and every bin zero afterwards.
- Backpressure: toggle `out_ready` every 3 cycles with `HISTMEM_WORD=8`. Expect no lost or duplicated words, `out_data` stable while stalled, and `mem_wren` never high while the FIFO is full in `RD`.
- `clear_only`: start with `clear_only=1` on a memory full of 0xFFFF. Expect `out_dv` never asserted, all bins 0, and `done` after `4*HISTMEM_WORD+1` cycles.
- Start while busy: pulse `start` again at cycle 100. Expect no restart and the word count unchanged.
- Reset mid-sweep: assert `reset` at bin 5 of 8. Expect all outputs at their reset values the next cycle. A subsequent `start` streams bins 0..7, with bins 0..4 reading 0.
- Non-power-of-two size: `HISTMEM_WORD=6`. Expect exactly 6 words, `out_last` on bin 5, and `mem_address` never reaching 6.
